// File: rtl/ctrl_ramdrv_wrbuf_pkg.sv
// Shared constants for the ring-buffer write controller: FSM state encodings
// and the length of the read-driver init pulse.
package ctrl_ramdrv_wrbuf_pkg;

    localparam logic [2:0] ST_UNCFG   = 3'd0;
    localparam logic [2:0] ST_ACCEPT  = 3'd1;
    localparam logic [2:0] ST_WRITE   = 3'd2;
    localparam logic [2:0] ST_PUBLISH = 3'd3;
    localparam logic [2:0] ST_BUSY    = 3'd4;
    localparam logic [2:0] ST_PREFILL = 3'd5;

    // Read driver latches the head on the first init cycle, its start address on the second.
    localparam int PUB_LEN = 2;

endpackage

// File: rtl/ctrl_ramdrv_wrbuf_if.sv
// Sample stream and RAM write bus of the ring-buffer write controller.
interface ctrl_ramdrv_wrbuf_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    modport master (
        output s_valid, s_data,
        input  s_ready, ram_we, ram_waddr, ram_wdata
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, ram_we, ram_waddr, ram_wdata
    );
endinterface

// File: rtl/ctrl_ramdrv_wrbuf_ptr.sv
// Wrapping buffer offset: load a value, or advance by one and wrap to 0 after len.
module ctrl_wrbuf_ptr #(
    parameter int OFST_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [OFST_WIDTH-1:0] load_val_i,
    input  logic                  inc_i,
    input  logic [OFST_WIDTH-1:0] len_i,
    output logic [OFST_WIDTH-1:0] ofs_o
);
    logic [OFST_WIDTH-1:0] ofs_q, ofs_d;

    always_comb begin
        ofs_d = ofs_q;
        if (load_i) begin
            ofs_d = load_val_i;
        end else if (inc_i) begin
            ofs_d = (ofs_q == len_i) ? '0 : ofs_q + OFST_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ofs_q <= '0;
        end else begin
            ofs_q <= ofs_d;
        end
    end

    assign ofs_o = ofs_q;
endmodule

// File: rtl/ctrl_ramdrv_wrbuf.sv
// Write-side controller for the filter sample ring buffer.
// Define CTRL_WRBUF_PREFILL_EN to zero-fill the buffer after every valid load.
module ctrl_ramdrv_wrbuf
    import ctrl_ramdrv_wrbuf_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int OFST_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int STEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_load_i,
    input  logic [ADDR_WIDTH-1:0] cfg_uptr_i,
    input  logic [ADDR_WIDTH-1:0] cfg_lptr_i,
    input  logic [STEP_WIDTH-1:0] cfg_step_i,
    output logic                  cfg_err_o,
    ctrl_ramdrv_wrbuf_if.slave    bus,
    output logic [ADDR_WIDTH-1:0] data_uptr_o,
    output logic [ADDR_WIDTH-1:0] data_lptr_o,
    output logic [OFST_WIDTH-1:0] head_offset_o,
    output logic                  rd_init_o,
    input  logic                  rd_done_i
);
    localparam logic [ADDR_WIDTH-1:0] LEN_MAX = ADDR_WIDTH'((1 << OFST_WIDTH) - 1);

    function automatic logic [ADDR_WIDTH-1:0] word_ext(input logic [OFST_WIDTH-1:0] ofs);
        return ADDR_WIDTH'(ofs);
    endfunction

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] uptr_q, uptr_d, lptr_q, lptr_d;
    logic [OFST_WIDTH-1:0] len_q, len_d;
    logic [STEP_WIDTH-1:0] step_q, step_d, cnt_q, cnt_d;
    logic [1:0]            pub_q, pub_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [DATA_WIDTH-1:0] sample_q;
    logic [ADDR_WIDTH-1:0] len_w;
    logic                  cfg_bad, load_ok, xfer;
    logic [STEP_WIDTH-1:0] step_eff, cnt_inc;
    logic [OFST_WIDTH-1:0] head;

    assign len_w    = cfg_lptr_i - cfg_uptr_i;
    assign cfg_bad  = (cfg_lptr_i < cfg_uptr_i) || (len_w > LEN_MAX);
    assign load_ok  = cfg_load_i && !cfg_bad;
    assign xfer     = bus.s_valid && bus.s_ready;
    assign step_eff = (step_q == '0) ? STEP_WIDTH'(1) : step_q;
    assign cnt_inc  = cnt_q + STEP_WIDTH'(1);

    // Loading len as the head makes the first write land on offset 0.
    ctrl_wrbuf_ptr #(.OFST_WIDTH(OFST_WIDTH)) u_head (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_ok),
        .load_val_i (len_w[OFST_WIDTH-1:0]),
        .inc_i      (xfer),
        .len_i      (len_q),
        .ofs_o      (head)
    );

`ifdef CTRL_WRBUF_PREFILL_EN
    logic [OFST_WIDTH-1:0] pf_ofs;

    ctrl_wrbuf_ptr #(.OFST_WIDTH(OFST_WIDTH)) u_fill (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_ok),
        .load_val_i ({OFST_WIDTH{1'b0}}),
        .inc_i      (state_q == ST_PREFILL),
        .len_i      (len_q),
        .ofs_o      (pf_ofs)
    );
`endif

    always_comb begin
        bus.s_ready   = (state_q == ST_ACCEPT) && !cfg_load_i;
        bus.ram_we    = 1'b0;
        bus.ram_waddr = '0;
        bus.ram_wdata = '0;
        if (state_q == ST_WRITE) begin
            bus.ram_we    = 1'b1;
            bus.ram_waddr = uptr_q + word_ext(head);
            bus.ram_wdata = sample_q;
        end
`ifdef CTRL_WRBUF_PREFILL_EN
        else if (state_q == ST_PREFILL) begin
            bus.ram_we    = 1'b1;
            bus.ram_waddr = uptr_q + word_ext(pf_ofs);
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        uptr_d    = uptr_q;
        lptr_d    = lptr_q;
        len_d     = len_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        pub_d     = pub_q;
        cfg_err_d = cfg_err_q;
        if (cfg_load_i) begin
            len_d     = len_w[OFST_WIDTH-1:0];
            cfg_err_d = cfg_bad;
            pub_d     = '0;
            if (cfg_bad) begin
                state_d = ST_UNCFG;
            end else begin
                uptr_d = cfg_uptr_i;
                lptr_d = cfg_lptr_i;
                step_d = cfg_step_i;
                cnt_d  = '0;
`ifdef CTRL_WRBUF_PREFILL_EN
                state_d = ST_PREFILL;
`else
                state_d = ST_ACCEPT;
`endif
            end
        end else begin
            case (state_q)
                ST_ACCEPT: if (xfer) state_d = ST_WRITE;
                ST_WRITE: begin
                    if (cnt_inc == step_eff) begin
                        cnt_d   = '0;
                        state_d = ST_PUBLISH;
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = ST_ACCEPT;
                    end
                end
                ST_PUBLISH: begin
                    pub_d = pub_q + 2'd1;
                    if (pub_q == 2'(PUB_LEN - 1)) begin
                        pub_d   = '0;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: if (rd_done_i) state_d = ST_ACCEPT;
`ifdef CTRL_WRBUF_PREFILL_EN
                ST_PREFILL: if (pf_ofs == len_q) state_d = ST_ACCEPT;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_UNCFG;
            uptr_q    <= '0;
            lptr_q    <= '0;
            len_q     <= '0;
            step_q    <= '0;
            cnt_q     <= '0;
            pub_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            uptr_q    <= uptr_d;
            lptr_q    <= lptr_d;
            len_q     <= len_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            pub_q     <= pub_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Sample data is gated at the RAM port, so it needs no reset.
    always_ff @(posedge clk) begin
        if (xfer) sample_q <= bus.s_data;
    end

    assign cfg_err_o     = cfg_err_q;
    assign data_uptr_o   = uptr_q;
    assign data_lptr_o   = lptr_q;
    assign head_offset_o = head;
    assign rd_init_o     = (state_q == ST_PUBLISH);
endmodule

// File: tb/tb_ctrl_ramdrv_wrbuf.sv
// Randomized scoreboard bench for the ring-buffer write controller.
module tb_ctrl_ramdrv_wrbuf;
    localparam int AW = 12;
    localparam int OW = 10;
    localparam int DW = 16;
    localparam int SW = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [OW-1:0] head;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_load = 1'b0;
    logic [AW-1:0] cfg_uptr = '0;
    logic [AW-1:0] cfg_lptr = '0;
    logic [SW-1:0] cfg_step = '0;
    logic          cfg_err;
    logic [AW-1:0] data_uptr, data_lptr;
    logic [OW-1:0] head_offset;
    logic          rd_init;
    logic          rd_done = 1'b0;

    int  checks = 0;
    int  errors = 0;
    int  rdi_cycles = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    // Reference model of the buffer: writes land at uptr + (n mod (len+1)).
    int m_uptr, m_len, m_step_eff, m_wr, m_inpass, m_passes;

    ctrl_ramdrv_wrbuf_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ctrl_ramdrv_wrbuf #(
        .ADDR_WIDTH(AW), .OFST_WIDTH(OW), .DATA_WIDTH(DW), .STEP_WIDTH(SW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_load_i    (cfg_load),
        .cfg_uptr_i    (cfg_uptr),
        .cfg_lptr_i    (cfg_lptr),
        .cfg_step_i    (cfg_step),
        .cfg_err_o     (cfg_err),
        .bus           (bus),
        .data_uptr_o   (data_uptr),
        .data_lptr_o   (data_lptr),
        .head_offset_o (head_offset),
        .rd_init_o     (rd_init),
        .rd_done_i     (rd_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.ram_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h, expected no write", bus.ram_waddr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.ram_waddr), 32'(mon_e.addr));
                chk("wr_data", 32'(bus.ram_wdata), 32'(mon_e.data));
                chk("wr_head", 32'(head_offset), 32'(mon_e.head));
            end
            chk("wr_in_bounds", 32'(bus.ram_waddr >= data_uptr && bus.ram_waddr <= data_lptr), 32'd1);
        end
        if (rst_n && rd_init) rdi_cycles++;
    end

    task automatic do_load(input int up, input int lp, input int st, input bit with_valid);
        bit ok;
        int len;
        len = lp - up;
        ok  = (lp >= up) && (len <= (1 << OW) - 1);
`ifdef CTRL_WRBUF_PREFILL_EN
        if (ok) begin
            for (int a = up; a <= lp; a++) exp_q.push_back('{AW'(a), '0, OW'(len)});
        end
`endif
        cfg_load = 1'b1;
        cfg_uptr = AW'(up);
        cfg_lptr = AW'(lp);
        cfg_step = SW'(st);
        if (with_valid) begin
            bus.s_valid = 1'b1;
            bus.s_data  = DW'($urandom);
            #1;
            chk("s_ready_during_load", 32'(bus.s_ready), 32'd0);
        end
        @(negedge clk);
        cfg_load    = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        chk("cfg_err", 32'(cfg_err), 32'(!ok));
        chk("rd_init_after_load", 32'(rd_init), 32'd0);
        if (ok) begin
            m_uptr     = up;
            m_len      = len;
            m_step_eff = (st == 0) ? 1 : st;
            m_wr       = 0;
            m_inpass   = 0;
            chk("head_after_load", 32'(head_offset), 32'(len));
            chk("uptr_after_load", 32'(data_uptr), 32'(up));
            chk("lptr_after_load", 32'(data_lptr), 32'(lp));
`ifdef CTRL_WRBUF_PREFILL_EN
            chk("s_ready_prefill", 32'(bus.s_ready), 32'd0);
`else
            chk("ram_we_after_load", 32'(bus.ram_we), 32'd0);
            chk("s_ready_after_load", 32'(bus.s_ready), 32'd1);
`endif
        end else begin
            chk("s_ready_bad_cfg", 32'(bus.s_ready), 32'd0);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input bit do_done);
        int n;
        int ofs;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        #1;
        while (!bus.s_ready && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.s_ready) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got s_ready 0, expected 1 within 3000 cycles");
            bus.s_valid = 1'b0;
            return;
        end
        ofs = m_wr % (m_len + 1);
        exp_q.push_back('{AW'(m_uptr + ofs), d, OW'(ofs)});
        m_wr++;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_data  = DW'($urandom);
        @(negedge clk);
        #1;
        chk("write_latency", 32'(bus.ram_we), 32'd1);
        m_inpass++;
        if (m_inpass == m_step_eff) begin
            m_inpass = 0;
            m_passes++;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                #1;
                chk("rd_init_pulse", 32'(rd_init), 32'd1);
                chk("s_ready_publish", 32'(bus.s_ready), 32'd0);
            end
            if (do_done) begin
                repeat ($urandom_range(1, 4)) begin
                    @(negedge clk);
                    #1;
                    chk("busy_hold", {30'd0, rd_init, bus.s_ready}, 32'd0);
                end
                rd_done = 1'b1;
                @(negedge clk);
                #1;
                rd_done = 1'b0;
                chk("s_ready_after_done", 32'(bus.s_ready), 32'd1);
            end else begin
                @(negedge clk);
                #1;
                chk("rd_init_end", 32'(rd_init), 32'd0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len, up, st, n;
        m_passes    = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'hBEEF;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("rst_waddr_wdata", {4'd0, bus.ram_waddr, bus.ram_wdata}, 32'd0);
        chk("rst_rd_init_err", {30'd0, rd_init, cfg_err}, 32'd0);
        chk("rst_head", 32'(head_offset), 32'd0);
        chk("rst_bounds", {8'd0, data_uptr, data_lptr}, 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("uncfg_s_ready", 32'(bus.s_ready), 32'd0);
            chk("uncfg_ram_we", 32'(bus.ram_we), 32'd0);
        end
        bus.s_valid = 1'b0;

        // Wrap around a four-entry buffer, one sample per pass.
        do_load(12'h100, 12'h103, 1, 1'b0);
        for (int i = 0; i < 5; i++) send(DW'(16'hA1 + i), 1'b1);

        // Three samples per pass.
        do_load(12'h300, 12'h309, 3, 1'b0);
        for (int i = 0; i < 6; i++) send(DW'($urandom), 1'b1);

        // Rejected loads, then the largest legal buffer with step 0.
        do_load(12'h200, 12'h1FF, 1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("err_s_ready", 32'(bus.s_ready), 32'd0);
        end
        do_load(12'h000, 12'h400, 1, 1'b0);
        do_load(12'h000, 12'h3FF, 0, 1'b0);
        for (int i = 0; i < 3; i++) send(DW'($urandom), 1'b1);

        // Reload while waiting for the filter pass, with a sample offered.
        do_load(12'h040, 12'h047, 2, 1'b0);
        send(DW'($urandom), 1'b1);
        send(DW'($urandom), 1'b0);
        do_load(12'h040, 12'h047, 2, 1'b1);
        send(DW'(16'h5A5A), 1'b1);

        // Single-entry buffer.
        do_load(12'h055, 12'h055, 2, 1'b0);
        for (int i = 0; i < 4; i++) send(DW'($urandom), 1'b1);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_head", 32'(head_offset), 32'd0);
        chk("async_rst_uptr", 32'(data_uptr), 32'd0);
        chk("async_rst_ready", 32'(bus.s_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int c = 0; c < 6; c++) begin
            len = (c == 0) ? 1023 : $urandom_range(0, 24);
            up  = (c == 1) ? 4095 - len : $urandom_range(0, 4095 - len);
            st  = $urandom_range(0, 15);
            do_load(up, up + len, st, 1'b0);
            n = $urandom_range(5, 30);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                send(DW'($urandom), 1'b1);
            end
        end

        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("rd_init_cycles", 32'(rdi_cycles), 32'(2 * m_passes));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
